// File: rtl/cavlc_bitstream_aligner_if.sv
// Bitstream handshake and window bus between the CAVLC aligner, its word feeder
// and the syntax-element decoders.
interface cavlc_bitstream_aligner_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned WIN_W = 16
);
    logic [IN_W-1:0]  InData;
    logic             InValid;
    logic             InReady;
    logic             ConsumeEn;
    logic [4:0]       ConsumeLen;
    logic             AlignEn;
    logic             Flush;
    logic [WIN_W-1:0] BitStreamShifted;
    logic             WindowValid;
    logic [6:0]       BitCount;
    logic [2:0]       BitPos;
    logic             Err;

    modport master (
        output InData, InValid, ConsumeEn, ConsumeLen, AlignEn, Flush,
        input  InReady, BitStreamShifted, WindowValid, BitCount, BitPos, Err
    );

    modport slave (
        input  InData, InValid, ConsumeEn, ConsumeLen, AlignEn, Flush,
        output InReady, BitStreamShifted, WindowValid, BitCount, BitPos, Err
    );
endinterface

// File: rtl/cavlc_bitstream_aligner.sv
// Left-justified bit buffer feeding CAVLC decoders: loads 32-bit words, presents the
// next 16 unconsumed bits and advances by the codeword length handed back.
module cavlc_bitstream_aligner #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned WIN_W = 16,
    parameter int unsigned BUF_W = 64
) (
    input logic                     Clk,
    input logic                     Reset,
    cavlc_bitstream_aligner_if.slave bs
);
    localparam int unsigned CNT_W   = 7;
    localparam logic [4:0]  WIN_LEN = 5'(WIN_W);

    logic [BUF_W-1:0] bit_buf_q, bit_buf_nxt, ins_bits;
    logic [CNT_W-1:0] count_q, count_nxt, drop, remain, align_len;
    logic [2:0]       pos_q, pos_nxt;
    logic             err_q, err_nxt;
    logic             ready_q, ready_nxt;
    logic             wvalid_q, wvalid_nxt;
    logic             accept;

    // Removal amount, error detection and buffer/count update for this cycle
    always_comb begin
        accept      = bs.InValid & ready_q;
        drop        = '0;
        err_nxt     = err_q;
        align_len   = CNT_W'(3'(3'd0 - pos_q));

        if (bs.AlignEn) begin
            if (align_len > count_q) err_nxt = 1'b1;
            else                     drop    = align_len;
            if (bs.ConsumeEn)        err_nxt = 1'b1;
        end else if (bs.ConsumeEn) begin
            if ((bs.ConsumeLen > WIN_LEN) || (CNT_W'(bs.ConsumeLen) > count_q))
                err_nxt = 1'b1;
            else
                drop = CNT_W'(bs.ConsumeLen);
        end

        // New word lands directly behind whatever survives the removal
        remain      = count_q - drop;
        ins_bits    = accept ? ({bs.InData, {(BUF_W-IN_W){1'b0}}} >> remain) : '0;
        bit_buf_nxt = (bit_buf_q << drop) | ins_bits;
        count_nxt   = remain + (accept ? CNT_W'(IN_W) : CNT_W'(0));
        pos_nxt     = pos_q + drop[2:0];

        if (bs.Flush) begin
            bit_buf_nxt = '0;
            count_nxt   = '0;
            pos_nxt     = '0;
            err_nxt     = 1'b0;
        end

        ready_nxt  = (count_nxt <= CNT_W'(BUF_W - IN_W));
        wvalid_nxt = (count_nxt >= CNT_W'(WIN_W));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bit_buf_q <= '0;
            count_q   <= '0;
            pos_q     <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            wvalid_q  <= 1'b0;
        end else begin
            bit_buf_q <= bit_buf_nxt;
            count_q   <= count_nxt;
            pos_q     <= pos_nxt;
            err_q     <= err_nxt;
            ready_q   <= ready_nxt;
            wvalid_q  <= wvalid_nxt;
        end
    end

    assign bs.BitStreamShifted = bit_buf_q[BUF_W-1 -: WIN_W];
    assign bs.WindowValid      = wvalid_q;
    assign bs.BitCount         = count_q;
    assign bs.BitPos           = pos_q;
    assign bs.Err              = err_q;
    assign bs.InReady          = ready_q;
endmodule

// File: doc/cavlc_bitstream_aligner.md
Name: cavlc_bitstream_aligner

Overview:
- Upstream feeder for the CAVLC syntax-element decoders, including the coeff_token lookup.
- Accepts MSB-first 32-bit slice-data words over a valid/ready handshake and holds them in a 64-bit left-justified bit buffer.
- Always presents the next 16 unconsumed bits as BitStreamShifted.
- Downstream decoders return the codeword length they used; the block advances by that many bits. It also supports byte alignment and a full flush at slice boundaries.

Parameters:
- IN_W, 32, input word width in bits.
- WIN_W, 16, window width presented to decoders; must satisfy WIN_W <= IN_W.
- BUF_W, 64, bit buffer depth; must satisfy BUF_W >= 2*IN_W.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- InData  in  IN_W  bitstream word; bit IN_W-1 is first in stream order.
- InValid  in  1  InData is valid.
- InReady  out  1  block accepts InData this cycle.
- ConsumeEn  in  1  advance the window by ConsumeLen bits.
- ConsumeLen  in  5  bits to consume, 0..WIN_W.
- AlignEn  in  1  discard bits up to the next byte boundary.
- Flush  in  1  discard all buffered bits and reset the bit position.
- BitStreamShifted  out  WIN_W  next WIN_W unconsumed bits, MSB = next bit.
- WindowValid  out  1  at least WIN_W bits are buffered.
- BitCount  out  7  number of valid bits in the buffer, 0..BUF_W.
- BitPos  out  3  total bits consumed since the last Flush/Reset, mod 8.
- Err  out  1  sticky protocol-error flag.

Behaviour:
- State: Buf[BUF_W-1:0], Count[6:0], BitPos[2:0], Err.
  - Reset sets all of them to 0.
  - Outputs after reset: BitStreamShifted=0, WindowValid=0, BitCount=0, BitPos=0, Err=0, InReady=1.
- BitStreamShifted = Buf[BUF_W-1 -: WIN_W].
  - This is driven straight from a register; it has no combinational path from any input.
  - Bits below Count are always 0.
- WindowValid = (Count >= WIN_W).
- InReady = (Count <= BUF_W-IN_W).
  - It is a registered-state function only and does not depend on the same-cycle consume.
- Accept = InValid & InReady.
- Per-cycle amount removed, d, in priority order:
  1. Flush: discard everything. Buf=0, Count=0, BitPos=0, Err=0. Accept is ignored, so the word is lost, and upstream must not present data during Flush. AlignEn and ConsumeEn are ignored.
  2. AlignEn: d = (8-BitPos) mod 8. If d > Count, nothing is removed and Err is set. If ConsumeEn is also high, the consume is dropped and Err is set.
  3. ConsumeEn: d = ConsumeLen. If ConsumeLen > WIN_W or ConsumeLen > Count, nothing is removed and Err is set.
  4. Otherwise d = 0.
- Update, when not flushing:
  - Buf' = (Buf << d), then if Accept, InData is OR-ed in at bit position BUF_W-1-(Count-d) downward.
  - Count' = Count - d + (Accept ? IN_W : 0). Count' never exceeds BUF_W.
  - BitPos' = BitPos + d (mod 8).
- Latency:
  - A word accepted in cycle N is visible in the window in cycle N+1.
  - A consume in cycle N shows the new window in cycle N+1.
  - Back-to-back consumes every cycle are supported while WindowValid stays high.
- Simultaneous consume and load in the same cycle is legal; new bits land directly after the remaining bits.
- ConsumeLen = 0 is a legal no-op.
- Consumes with ConsumeLen <= Count are allowed while WindowValid=0. This lets the decoder drain the stream tail.
- Err is cleared only by Reset or Flush.

Test Plan:
- Reset, then InData=32'hA5C3_0F00 valid for one cycle -> next cycle BitStreamShifted=16'hA5C3, BitCount=32, WindowValid=1, InReady=1.
- From that state, ConsumeEn with ConsumeLen=4 -> window=16'h5C30, BitCount=28, BitPos=4. Then ConsumeLen=12 -> window=16'h0F00, BitCount=16, BitPos=0.
- Fill with words 32'hFFFF_FFFF and 32'h0000_0001, then hold InValid=1 -> BitCount=64, InReady=0 and the third word is not accepted. ConsumeLen=16 -> BitCount=48; InReady stays 0 because 48 > 32.
- With BitCount=20 and BitPos=0: ConsumeLen=3, then AlignEn -> 5 bits dropped, BitPos=0, BitCount=12, WindowValid=0, Err=0. A second AlignEn removes 0 bits.
- With BitCount=10, ConsumeLen=12 -> no change, Err=1. Then AlignEn and ConsumeEn together -> only the align is applied, Err stays 1. Then Flush -> BitCount=0, BitPos=0, Err=0, window=0.
- With BitCount=24, a word accepted in the same cycle as ConsumeLen=8 -> BitCount=48, and the window shows old bits [15:0] of the remainder followed by the new word's MSBs in the correct order.
